// File: rtl/seq_mac_pkg.sv
// Shared types and defaults for the sequential multiply-accumulate block.
package seq_mac_pkg;

    // Sequencer states: waiting for operands, shifting/adding, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default unsigned operand width for a and b.
    localparam int DEFAULT_WIDTH = 8;

    // Width of the bit-index counter for a WIDTH-bit multiplier (at least 1 bit).
    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : seq_mac_pkg

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule : fa

// File: rtl/mac_rca.sv
// Parameterised ripple-carry adder chained from full-adder cells; purely combinational.
module mac_rca #(
    parameter int W = 17
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum
);

    // carry[i] is the carry into bit i; the chain starts with no carry in.
    logic [W-1:0] carry;
    // The MSB carry out can never be set because the operands are range-limited.
    logic         carry_unused;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        if (i < W - 1) begin : g_mid
            fa u_fa (
                .x  (x[i]),
                .y  (y[i]),
                .ci (carry[i]),
                .s  (sum[i]),
                .co (carry[i+1])
            );
        end else begin : g_msb
            fa u_fa (
                .x  (x[i]),
                .y  (y[i]),
                .ci (carry[i]),
                .s  (sum[i]),
                .co (carry_unused)
            );
        end
    end

endmodule : mac_rca

// File: rtl/seq_mac.sv
// Sequential shift-and-add multiply-accumulate: result = c + a*b, one multiplier bit per cycle.
module seq_mac
    import seq_mac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ACC_W = 2 * WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2*WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             busy
);

    localparam int CNT_W = count_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Only the exact-fit accumulator width is supported; it guarantees no overflow.
    if (ACC_W != 2 * WIDTH + 1) begin : g_bad_acc_w
        $error("seq_mac: ACC_W must equal 2*WIDTH+1");
    end

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] partial;
    logic [ACC_W-1:0] acc_sum;
    logic             accept;
    logic             last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (count == LAST_BIT);

    // Shifted multiplicand selected by the current multiplier bit; every bit takes a cycle.
    always_comb begin
        partial = '0;
        if (b_reg[count]) begin
            partial = ACC_W'(a_reg) << count;
        end
    end

    mac_rca #(
        .W (ACC_W)
    ) u_rca (
        .x   (acc),
        .y   (partial),
        .sum (acc_sum)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, accumulator and bit counter; inputs are only sampled on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= ACC_W'(c);
            count <= '0;
        end else if (state == CALC) begin
            acc   <= acc_sum;
            count <= count + 1'b1;
        end
    end

    assign result = acc;

endmodule : seq_mac

// File: tb/tb_seq_mac.sv
// Directed self-checking bench for seq_mac with WIDTH=8.
module tb_seq_mac;

    localparam int WIDTH = 8;
    localparam int ACC_W = 2 * WIDTH + 1;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] c;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   result;
    logic               busy;

    int checks = 0;
    int errors = 0;

    seq_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full transaction: accept, scramble inputs, measure latency, check and drain.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic [15:0] tc, input logic [16:0] exp);
        int cycles;
        a        = ta;
        b        = tb_;
        c        = tc;
        in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_;
        c        = ~tc;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_calc"}, 32'(in_ready), 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            step();
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'd8);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_drained_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drained_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c         = '0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Basic product plus addend.
        run_op("t1", 8'd3, 8'd5, 16'd7, 17'h00016);
        // Largest operands reach the top accumulator bit.
        run_op("t2", 8'hFF, 8'hFF, 16'hFFFF, 17'h1FE00);
        // Zero multiplier still takes the full eight cycles.
        run_op("t3", 8'hA5, 8'h00, 16'h1234, 17'h01234);

        // Back-pressure: result held while consumer stalls and inputs churn.
        a        = 8'h12;
        b        = 8'h34;
        c        = 16'h0100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_result0", 32'(result), 32'h000004A8);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = a + 8'h11;
            b        = b ^ 8'hFF;
            c        = c + 16'h0F0F;
            out_ready = 1'b0;
            step();
            check("bp_hold_result", 32'(result), 32'h000004A8);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check("bp_no_restart", 32'(busy), 32'd0);

        // Reset in the middle of a calculation discards it.
        a        = 8'hFF;
        b        = 8'hFF;
        c        = 16'h0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        check("post_rst_result", 32'(result), 32'd0);
        run_op("t5", 8'd2, 8'd2, 16'd0, 17'h00004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_seq_mac
